// File: rtl/seq_divider.sv
// seq_divider: iterative restoring unsigned divider, one quotient bit per clock.
// Divides a 2*len-bit dividend by a len-bit divisor. A high dividend half that is
// not below the divisor (including a zero divisor) is flagged as overflow at once,
// without iterating.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request, sampled only while idle
//   P     - 2*len-bit dividend, captured on the accepting edge
//   B     - len-bit divisor, captured on the accepting edge
//   busy  - high whenever the divider is not idle
//   done  - one-cycle pulse; Q/R/ovf valid from this cycle
//   Q, R  - quotient and remainder, held until the next result
//   ovf   - quotient does not fit in len bits, or B == 0
module seq_divider #(
    parameter int unsigned len = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*len-1:0]   P,
    input  logic [len-1:0]     B,
    output logic               busy,
    output logic               done,
    output logic [len-1:0]     Q,
    output logic [len-1:0]     R,
    output logic               ovf
);

    localparam int unsigned CNT_W = $clog2(len + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [len-1:0]   b_q,     b_d;
    logic [len:0]     rem_q,   rem_d;
    logic [len-1:0]   quo_q,   quo_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [len-1:0]   q_q,     q_d;
    logic [len-1:0]   r_q,     r_d;
    logic             ovf_q,   ovf_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Restoring step datapath: rem stays below B, so rem[len] is never set
    // before the shift and can be dropped.
    logic [len:0]     rem_shift;
    logic [len+1:0]   diff;
    logic             fits;
    logic [len:0]     rem_next;
    logic [len-1:0]   quo_next;

    always_comb begin
        rem_shift = {rem_q[len-1:0], quo_q[len-1]};
        diff      = {1'b0, rem_shift} - {2'b00, b_q};
        fits      = ~diff[len+1];
        rem_next  = fits ? diff[len:0] : rem_shift;
        quo_next  = {quo_q[len-2:0], fits};
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    b_d   = B;
                    rem_d = {1'b0, P[2*len-1:len]};
                    quo_d = P[len-1:0];
                    if (P[2*len-1:len] >= B) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        q_d     = '1;
                        r_d     = '0;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CNT_W'(len);
                    end
                end
            end
            RUN: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    q_d     = quo_next;
                    r_d     = rem_next[len-1:0];
                    ovf_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes the expected {Q,R,ovf} for each
// accepted request; a monitor pops and compares on every done pulse. Cycle-exact
// busy/done timing is checked inline by the stimulus.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] P;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic [7:0]  Q;
    logic [7:0]  R;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    logic [16:0] sb[$];
    logic [16:0] mon_exp;

    always #5 clk = ~clk;

    seq_divider #(.len(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .P     (P),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .ovf   (ovf)
    );

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(logic [7:0] q, logic [7:0] r, logic o);
        sb.push_back({q, r, o});
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result: unexpected done Q=%0d R=%0d ovf=%0d", Q, R, ovf);
            end else begin
                mon_exp = sb.pop_front();
                if ({Q, R, ovf} !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got Q=%0d R=%0d ovf=%0d expected Q=%0d R=%0d ovf=%0d",
                             Q, R, ovf, mon_exp[16:9], mon_exp[8:1], mon_exp[0]);
                end
            end
        end
    end

    // Issue one request and wait (bounded) until the divider is idle again
    task automatic run_div(input logic [15:0] p, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic eo);
        int n;
        @(negedge clk);
        P = p; B = b; start = 1'b1;
        push_exp(eq, er, eo);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("busy_timeout", 1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b;
        rst = 1'b1; start = 1'b0; P = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_q",    int'(Q),    0);
        chk("reset_r",    int'(R),    0);
        chk("reset_ovf",  int'(ovf),  0);
        rst = 1'b0;

        // 1000 / 7 with exact busy/done timing
        @(negedge clk);
        P = 16'd1000; B = 8'd7; start = 1'b1;
        push_exp(8'd142, 8'd6, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; P = 16'hFFFF; B = 8'd1; end
            chk($sformatf("t1_busy_c%0d", k), int'(busy), (k <= 9) ? 1 : 0);
            chk($sformatf("t1_done_c%0d", k), int'(done), (k == 9) ? 1 : 0);
        end

        // Reset mid-divide, then a fresh divide
        @(negedge clk);
        P = 16'd1000; B = 8'd7; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            chk($sformatf("rmid_done_c%0d", k), int'(done), 0);
            if (k == 4) rst = 1'b1;
            if (k == 5) begin
                rst = 1'b0;
                chk("rmid_busy", int'(busy), 0);
                chk("rmid_q",    int'(Q),    0);
                chk("rmid_r",    int'(R),    0);
                chk("rmid_ovf",  int'(ovf),  0);
            end
        end
        @(negedge clk);
        P = 16'd1000; B = 8'd7; start = 1'b1;
        push_exp(8'd142, 8'd6, 1'b0);
        for (int k = 7; k <= 16; k++) begin
            @(negedge clk);
            if (k == 7) start = 1'b0;
            chk($sformatf("rnew_done_c%0d", k), int'(done), (k == 15) ? 1 : 0);
        end

        // Overflow timing: done in cycle 1, idle in cycle 2
        @(negedge clk);
        P = 16'h0800; B = 8'h08; start = 1'b1;
        push_exp(8'hFF, 8'h00, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            chk($sformatf("ovf_busy_c%0d", k), int'(busy), (k == 1) ? 1 : 0);
            chk($sformatf("ovf_done_c%0d", k), int'(done), (k == 1) ? 1 : 0);
        end

        run_div(16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1);
        run_div(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0);
        run_div(16'h0000, 8'h01, 8'h00, 8'h00, 1'b0);
        run_div(16'h00FF, 8'hFF, 8'h01, 8'h00, 1'b0);
        run_div(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0);
        run_div(16'hFF00, 8'hFF, 8'hFF, 8'h00, 1'b1);

        // start held high; operands scrambled while busy
        @(negedge clk);
        P = 16'd100; B = 8'd3; start = 1'b1;
        repeat (3) push_exp(8'd33, 8'd1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk($sformatf("hold_done_c%0d", k), int'(done), (k % 10 == 9) ? 1 : 0);
            if (k == 30) start = 1'b0;
            if (busy) begin
                P = 16'($urandom);
                B = 8'($urandom);
            end else begin
                P = 16'd100; B = 8'd3;
            end
        end

        // rst and start together: request dropped
        @(negedge clk);
        rst = 1'b1; start = 1'b1; P = 16'd50; B = 8'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        @(negedge clk);
        chk("rst_start_busy2", int'(busy), 0);
        chk("rst_start_done",  int'(done), 0);

        // Inverse of multiplication: random A*B, then every A with B=1
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_div({8'h00, a} * {8'h00, b}, b, a, 8'h00, 1'b0);
        end
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            run_div({8'h00, a}, 8'h01, a, 8'h00, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
